// File: rtl/board_move_unit.sv
// Connect4 board store and move engine: drops pieces, scans one line direction per cycle for a
// win, then updates turn, status and full flags for the downstream game FSM.
module board_move_unit #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   drop_req_i,
  input  logic [2:0]             column_i,
  input  logic                   new_game_i,
  output logic                   invalid_move_o,
  output logic [1:0]             in_game_status_o,
  output logic                   player_turn_o,
  output logic                   board_full_o,
  output logic                   busy_o,
  output logic                   move_done_o,
  output logic [2*ROWS*COLS-1:0] board_state_o
);
  localparam int Cells = ROWS * COLS;
  localparam int HW    = $clog2(ROWS + 1);
  localparam int MW    = $clog2(Cells + 1);

  typedef enum logic [2:0] {
    StIdle, StPlace, StChk0, StChk1, StChk2, StChk3, StUpdate
  } state_e;

  state_e                  state_q, state_d;
  logic [2*Cells-1:0]      board_q, board_d;
  logic [COLS-1:0][HW-1:0] height_q, height_d;
  logic [MW-1:0]           moves_q, moves_d;
  logic [2:0]              col_q, col_d;
  logic [HW-1:0]           row_q, row_d;
  logic [1:0]              piece_q, piece_d;
  logic                    win_q, win_d;
  logic [1:0]              status_q, status_d;
  logic                    turn_q, turn_d;
  logic                    full_q, full_d;
  logic                    invalid_q, invalid_d;
  logic                    done_q, done_d;
  logic [HW-1:0]           h_sel;
  logic                    line_win;

  always_comb begin
    h_sel = '0;
    for (int c = 0; c < COLS; c++) begin
      if (int'(column_i) == c) h_sel = height_q[c];
    end
  end

  // Count matching pieces on both sides of the placed cell along the current state's direction.
  always_comb begin : scan_line
    int dr, dc, r, c, idx, cnt;
    logic run, in_rng;
    dr     = 0;
    dc     = 1;
    cnt    = 1;
    r      = 0;
    c      = 0;
    idx    = 0;
    run    = 1'b0;
    in_rng = 1'b0;
    case (state_q)
      StChk1:  begin dr = 1; dc = 0;  end
      StChk2:  begin dr = 1; dc = 1;  end
      StChk3:  begin dr = 1; dc = -1; end
      default: ;
    endcase
    for (int s = -1; s <= 1; s += 2) begin
      run = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        r      = int'(row_q) + s * k * dr;
        c      = int'(col_q) + s * k * dc;
        in_rng = (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
        idx    = in_rng ? 2 * (r * COLS + c) : 0;
        if (run && in_rng && (board_q[idx +: 2] == piece_q)) cnt++;
        else run = 1'b0;
      end
    end
    line_win = (cnt >= WIN_LEN);
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    height_d  = height_q;
    moves_d   = moves_q;
    col_d     = col_q;
    row_d     = row_q;
    piece_d   = piece_q;
    win_d     = win_q;
    status_d  = status_q;
    turn_d    = turn_q;
    full_d    = full_q;
    invalid_d = 1'b0;
    done_d    = 1'b0;
    if (new_game_i) begin
      state_d  = StIdle;
      board_d  = '0;
      height_d = '0;
      moves_d  = '0;
      win_d    = 1'b0;
      status_d = 2'b00;
      turn_d   = 1'b0;
      full_d   = 1'b0;
    end else begin
      case (state_q)
        // The move_done cycle still counts as busy, so requests there are ignored.
        StIdle: if (drop_req_i && !done_q) begin
          if (int'(column_i) >= COLS || int'(h_sel) >= ROWS || status_q != 2'b00 || full_q) begin
            invalid_d = 1'b1;
          end else begin
            col_d   = column_i;
            row_d   = h_sel;
            piece_d = {turn_q, ~turn_q};
            win_d   = 1'b0;
            state_d = StPlace;
          end
        end
        StPlace: begin
          board_d[2 * (int'(row_q) * COLS + int'(col_q)) +: 2] = piece_q;
          for (int c = 0; c < COLS; c++) begin
            if (int'(col_q) == c) height_d[c] = height_q[c] + 1'b1;
          end
          moves_d = moves_q + 1'b1;
          state_d = StChk0;
        end
        StChk0: begin win_d = win_q | line_win; state_d = StChk1; end
        StChk1: begin win_d = win_q | line_win; state_d = StChk2; end
        StChk2: begin win_d = win_q | line_win; state_d = StChk3; end
        StChk3: begin win_d = win_q | line_win; state_d = StUpdate; end
        StUpdate: begin
          if (win_q) status_d = piece_q;
          else       turn_d   = ~turn_q;
          full_d  = (int'(moves_q) == Cells);
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      board_q   <= '0;
      height_q  <= '0;
      moves_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      piece_q   <= '0;
      win_q     <= 1'b0;
      status_q  <= 2'b00;
      turn_q    <= 1'b0;
      full_q    <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      height_q  <= height_d;
      moves_q   <= moves_d;
      col_q     <= col_d;
      row_q     <= row_d;
      piece_q   <= piece_d;
      win_q     <= win_d;
      status_q  <= status_d;
      turn_q    <= turn_d;
      full_q    <= full_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign invalid_move_o   = invalid_q;
  assign in_game_status_o = status_q;
  assign player_turn_o    = turn_q;
  assign board_full_o     = full_q;
  assign busy_o           = (state_q != StIdle) | done_q;
  assign move_done_o      = done_q;
  assign board_state_o    = board_q;

endmodule

// File: tb/tb_board_move_unit.sv
// Bench for board_move_unit: directed game scenarios plus random play against a whole-board
// Connect4 reference model.
module tb_board_move_unit;
  localparam int R = 6;
  localparam int C = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             drop_req;
  logic [2:0]       column;
  logic             new_game;
  logic             invalid_move;
  logic [1:0]       status;
  logic             player_turn;
  logic             board_full;
  logic             busy;
  logic             move_done;
  logic [2*R*C-1:0] board;

  int checks = 0;
  int errors = 0;

  int mb[R][C];
  int mh[C];
  int mturn, mstatus, mmoves;
  bit mfull;

  always #5 clk = ~clk;

  board_move_unit #(.ROWS(R), .COLS(C), .WIN_LEN(4)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .drop_req_i       (drop_req),
    .column_i         (column),
    .new_game_i       (new_game),
    .invalid_move_o   (invalid_move),
    .in_game_status_o (status),
    .player_turn_o    (player_turn),
    .board_full_o     (board_full),
    .busy_o           (busy),
    .move_done_o      (move_done),
    .board_state_o    (board)
  );

  function automatic void model_clear();
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) mb[r][c] = 0;
    for (int c = 0; c < C; c++) mh[c] = 0;
    mturn = 0; mstatus = 0; mmoves = 0; mfull = 0;
  endfunction

  // Any four-in-a-row of piece p anywhere on the board.
  function automatic bit model_has_win(int p);
    int dr, dc, rr, cc;
    bit ok;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          ok = 1;
          for (int k = 0; k < 4; k++) begin
            rr = r + k * dr;
            cc = c + k * dc;
            if (rr < 0 || rr >= R || cc < 0 || cc >= C) ok = 0;
            else if (mb[rr][cc] != p) ok = 0;
          end
          if (ok) return 1;
        end
    return 0;
  endfunction

  function automatic bit model_accepts(int col);
    if (col >= C) return 0;
    return (mh[col] < R) && (mstatus == 0) && !mfull;
  endfunction

  function automatic void model_apply(int col);
    int p;
    p = mturn + 1;
    mb[mh[col]][col] = p;
    mh[col]++;
    mmoves++;
    if (model_has_win(p)) mstatus = p;
    else mturn = 1 - mturn;
    mfull = (mmoves == R * C);
  endfunction

  function automatic logic [2*R*C-1:0] model_vec();
    logic [2*R*C-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) v[2*(r*C+c) +: 2] = 2'(mb[r][c]);
    return v;
  endfunction

  // Issue one request and check the full response against the model.
  task automatic do_drop(input int col);
    bit acc;
    int n;
    acc = model_accepts(col);
    @(negedge clk); drop_req = 1'b1; column = 3'(col);
    @(negedge clk); drop_req = 1'b0;
    if (acc) begin
      model_apply(col);
      n = 0;
      while (move_done !== 1'b1 && n < 12) begin
        checks++;
        if (busy !== 1'b1 || invalid_move !== 1'b0) begin
          errors++;
          $display("FAIL busy_phase col=%0d cyc=%0d: busy=%b inv=%b want busy=1 inv=0",
                   col, n, busy, invalid_move);
        end
        @(negedge clk); n++;
      end
      checks++;
      if (n != 6) begin
        errors++;
        $display("FAIL done_latency col=%0d: got %0d cycles want 6", col, n);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_at_done: got %b want 1", busy); end
    end else begin
      checks++;
      if (invalid_move !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reject col=%0d: inv=%b busy=%b want inv=1 busy=0", col, invalid_move, busy);
      end
    end
    checks++;
    if (status !== 2'(mstatus)) begin
      errors++; $display("FAIL status col=%0d: got %b want %b", col, status, 2'(mstatus));
    end
    checks++;
    if (player_turn !== 1'(mturn)) begin
      errors++; $display("FAIL turn col=%0d: got %b want %b", col, player_turn, 1'(mturn));
    end
    checks++;
    if (board_full !== mfull) begin
      errors++; $display("FAIL full col=%0d: got %b want %b", col, board_full, mfull);
    end
    checks++;
    if (board !== model_vec()) begin
      errors++; $display("FAIL board col=%0d: got %h want %h", col, board, model_vec());
    end
    @(negedge clk);
    checks++;
    if (move_done !== 1'b0 || invalid_move !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse_end col=%0d: done=%b inv=%b busy=%b want 0 0 0",
               col, move_done, invalid_move, busy);
    end
  endtask

  task automatic do_new_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    model_clear();
    checks++;
    if (board !== '0 || status !== 2'b00 || player_turn !== 1'b0 || board_full !== 1'b0
        || busy !== 1'b0) begin
      errors++;
      $display("FAIL new_game_clear: board=%h st=%b turn=%b full=%b busy=%b want all 0",
               board, status, player_turn, board_full, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; drop_req = 1'b0; new_game = 1'b0; column = '0;
    #12;
    @(negedge clk); reset = 1'b0;
    model_clear();
    checks++;
    if (board !== '0 || status !== 2'b00 || player_turn !== 1'b0 || board_full !== 1'b0
        || invalid_move !== 1'b0 || busy !== 1'b0 || move_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: board=%h st=%b turn=%b full=%b inv=%b busy=%b done=%b",
               board, status, player_turn, board_full, invalid_move, busy, move_done);
    end
  endtask

  task automatic test_first_drop();
    do_drop(3);
    checks++;
    if (board[7:6] !== 2'b01 || player_turn !== 1'b1 || status !== 2'b00) begin
      errors++;
      $display("FAIL first_drop: cell=%b turn=%b st=%b want 01 1 00", board[7:6], player_turn, status);
    end
  endtask

  task automatic test_column_full();
    do_new_game();
    for (int i = 0; i < 7; i++) do_drop(0);
    checks++;
    if (player_turn !== 1'b0) begin
      errors++; $display("FAIL col_full_turn: got %b want 0", player_turn);
    end
  endtask

  task automatic test_horizontal_win();
    int seq[7] = '{0, 6, 1, 6, 2, 6, 3};
    do_new_game();
    for (int i = 0; i < 7; i++) do_drop(seq[i]);
    checks++;
    if (status !== 2'b01 || player_turn !== 1'b0) begin
      errors++; $display("FAIL horiz_win: st=%b turn=%b want 01 0", status, player_turn);
    end
  endtask

  task automatic test_diag_win();
    int seq[10] = '{4, 5, 3, 4, 2, 3, 2, 3, 2, 2};
    do_new_game();
    for (int i = 0; i < 10; i++) do_drop(seq[i]);
    checks++;
    if (status !== 2'b10 || player_turn !== 1'b1) begin
      errors++; $display("FAIL diag_win: st=%b turn=%b want 10 1", status, player_turn);
    end
    do_drop(0);
  endtask

  task automatic test_invalid_and_busy();
    int n;
    bit seen;
    do_new_game();
    do_drop(7);
    @(negedge clk); drop_req = 1'b1; column = 3'd1;
    @(negedge clk); drop_req = 1'b0;
    model_apply(1);
    @(negedge clk); drop_req = 1'b1; column = 3'd2;
    @(negedge clk); drop_req = 1'b0;
    checks++;
    if (invalid_move !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_drop: inv=%b busy=%b want 0 1", invalid_move, busy);
    end
    n = 0; seen = 0;
    while (move_done !== 1'b1 && n < 12) begin
      if (invalid_move === 1'b1) seen = 1;
      @(negedge clk); n++;
    end
    checks++;
    if (n != 4 || seen) begin
      errors++; $display("FAIL busy_done: cycles=%0d inv_seen=%b want 4 0", n, seen);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (invalid_move === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen || board !== model_vec() || player_turn !== 1'b1) begin
      errors++;
      $display("FAIL busy_no_queue: seen=%b board=%h turn=%b want 0 %h 1",
               seen, board, player_turn, model_vec());
    end
  endtask

  task automatic test_full_board();
    int pa[3] = '{0, 1, 4};
    int pb[3] = '{2, 3, 6};
    int pat[12] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    do_new_game();
    for (int p = 0; p < 3; p++) for (int i = 0; i < 12; i++) do_drop(pat[i] ? pb[p] : pa[p]);
    for (int i = 0; i < 6; i++) do_drop(5);
    checks++;
    if (board_full !== 1'b1 || status !== 2'b00) begin
      errors++; $display("FAIL full_board: full=%b st=%b want 1 00", board_full, status);
    end
    do_drop(1);
  endtask

  task automatic test_new_game_mid_move();
    bit seen;
    do_new_game();
    do_drop(4);
    @(negedge clk); drop_req = 1'b1; column = 3'd2;
    @(negedge clk); drop_req = 1'b0;
    @(negedge clk);
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    model_clear();
    checks++;
    if (board !== '0 || busy !== 1'b0 || move_done !== 1'b0 || player_turn !== 1'b0) begin
      errors++;
      $display("FAIL ng_mid: board=%h busy=%b done=%b turn=%b want 0", board, busy, move_done,
               player_turn);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (move_done === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL ng_no_done: got activity want none"); end
    do_drop(6);
  endtask

  task automatic test_reset_mid_move();
    @(negedge clk); drop_req = 1'b1; column = 3'd5;
    @(negedge clk); drop_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (board !== '0 || busy !== 1'b0 || move_done !== 1'b0 || status !== 2'b00
        || player_turn !== 1'b0 || board_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: board=%h busy=%b done=%b st=%b turn=%b full=%b want 0",
               board, busy, move_done, status, player_turn, board_full);
    end
    @(negedge clk); reset = 1'b0;
    model_clear();
    do_drop(5);
  endtask

  task automatic test_random_play();
    for (int g = 0; g < 3; g++) begin
      do_new_game();
      for (int i = 0; i < 45; i++) do_drop(int'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_first_drop();
    test_column_full();
    test_horizontal_win();
    test_diag_win();
    test_invalid_and_busy();
    test_full_board();
    test_new_game_mid_move();
    test_reset_mid_move();
    test_random_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
